cl_stream_cfg_regs: RTL

//  Responder end of cfg_bus: streaming control/status register block in one 256B cfg slot.

---
 rtl/cl_stream_cfg_regs.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/cl_stream_cfg_regs.sv
// Streaming control/status register block on cfg_bus: CTRL/STATUS/CYCLES/BEATS/SCRATCH plus the run FSM.
// Optional TIMEOUT register and auto-abort when CL_STREAM_TIMEOUT_EN is defined.
module cl_stream_cfg_regs #(
  parameter int          CNT_W       = 32,
  parameter logic [31:0] DEF_TIMEOUT = 32'd0
) (
  input  logic        clk,
  input  logic        sync_rst_n,
  input  logic        sh_cl_flr_assert_q,
  input  logic [31:0] cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        cfg_wr,
  input  logic        cfg_rd,
  output logic        cfg_ack,
  output logic [31:0] cfg_rdata,
  input  logic        stream_beat,
  input  logic        stream_done,
  output logic        stream_start,
  output logic        stream_abort,
  output logic        streaming_active
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_r;
  logic [CNT_W-1:0] cycles_r;
  logic [CNT_W-1:0] beats_r;
  logic [CNT_W-1:0] cycles_nxt_s;
  logic [CNT_W-1:0] beats_nxt_s;
  logic [31:0]      cycles_ext_s;
  logic [31:0]      cycles_nxt_ext_s;
  logic [31:0]      beats_ext_s;
  logic [31:0]      scratch_r;
  logic [31:0]      rdata_s;
  logic             done_r;
  logic [5:0]       addr_idx_s;
  logic             ctrl_wr_s;
  logic             status_wr_s;
  logic             scratch_wr_s;
  logic             start_req_s;
  logic             abort_req_s;
  logic             is_active_s;
  logic             start_go_s;
  logic             leave_s;
  logic             abort_fire_s;
  logic             done_set_s;
  logic             timeout_hit_s;
  logic             tmo_fire_s;
  logic             timeout_sticky_s;
  logic             unused_s;

`ifdef CL_STREAM_TIMEOUT_EN
  logic [31:0] timeout_lim_r;
  logic        timeout_r;
  logic        tmo_wr_s;
`endif

  // Request decode, saturating counter next values and run control terms
  always_comb begin
    addr_idx_s   = cfg_addr[7:2];
    ctrl_wr_s    = cfg_wr && (addr_idx_s == 6'd0);
    status_wr_s  = cfg_wr && (addr_idx_s == 6'd1);
    scratch_wr_s = cfg_wr && (addr_idx_s == 6'd4);
    start_req_s  = ctrl_wr_s && cfg_wdata[0] && !cfg_wdata[1];
    abort_req_s  = ctrl_wr_s && cfg_wdata[1];
    is_active_s  = (state_r == ST_ACTIVE);
    start_go_s   = !is_active_s && start_req_s && !sh_cl_flr_assert_q;

    if (cycles_r == CNT_MAX) begin
      cycles_nxt_s = cycles_r;
    end else begin
      cycles_nxt_s = cycles_r + CNT_ONE;
    end
    if (stream_beat && (beats_r != CNT_MAX)) begin
      beats_nxt_s = beats_r + CNT_ONE;
    end else begin
      beats_nxt_s = beats_r;
    end

    cycles_ext_s                 = 32'd0;
    cycles_ext_s[CNT_W-1:0]      = cycles_r;
    cycles_nxt_ext_s             = 32'd0;
    cycles_nxt_ext_s[CNT_W-1:0]  = cycles_nxt_s;
    beats_ext_s                  = 32'd0;
    beats_ext_s[CNT_W-1:0]       = beats_r;

`ifdef CL_STREAM_TIMEOUT_EN
    tmo_wr_s         = cfg_wr && (addr_idx_s == 6'd5);
    timeout_hit_s    = (timeout_lim_r != 32'd0) && (cycles_nxt_ext_s == timeout_lim_r);
    timeout_sticky_s = timeout_r;
    unused_s         = ^{cfg_addr[31:8], cfg_addr[1:0]};
`else
    timeout_hit_s    = 1'b0;
    timeout_sticky_s = 1'b0;
    unused_s         = ^{cfg_addr[31:8], cfg_addr[1:0], DEF_TIMEOUT, cycles_nxt_ext_s};
`endif

    // Exit priority: FLR, then datapath done, then sw abort, then timeout
    done_set_s   = is_active_s && stream_done && !sh_cl_flr_assert_q;
    tmo_fire_s   = is_active_s && timeout_hit_s && !sh_cl_flr_assert_q && !stream_done && !abort_req_s;
    leave_s      = is_active_s && (sh_cl_flr_assert_q || stream_done || abort_req_s || timeout_hit_s);
    abort_fire_s = is_active_s && (sh_cl_flr_assert_q || (!stream_done && abort_req_s) || tmo_fire_s);
  end

  // Read data mux, sampled from register state in the request cycle
  always_comb begin
    case (addr_idx_s)
      6'd0:    rdata_s = 32'd0;
      6'd1:    rdata_s = {29'd0, timeout_sticky_s, done_r, is_active_s};
      6'd2:    rdata_s = cycles_ext_s;
      6'd3:    rdata_s = beats_ext_s;
      6'd4:    rdata_s = scratch_r;
`ifdef CL_STREAM_TIMEOUT_EN
      6'd5:    rdata_s = timeout_lim_r;
`endif
      default: rdata_s = 32'hdead_beef;
    endcase
  end

  // Run FSM with registered start/abort pulses and active level
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      state_r          <= ST_IDLE;
      stream_start     <= 1'b0;
      stream_abort     <= 1'b0;
      streaming_active <= 1'b0;
    end else begin
      stream_start <= 1'b0;
      stream_abort <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start_go_s) begin
            state_r          <= ST_ACTIVE;
            stream_start     <= 1'b1;
            streaming_active <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (leave_s) begin
            state_r          <= ST_IDLE;
            streaming_active <= 1'b0;
            stream_abort     <= abort_fire_s;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          streaming_active <= 1'b0;
        end
      endcase
    end
  end

  // Cycle and beat counters: cleared on start, advance only while ACTIVE
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      cycles_r <= '0;
      beats_r  <= '0;
    end else if (start_go_s) begin
      cycles_r <= '0;
      beats_r  <= '0;
    end else if (is_active_s) begin
      cycles_r <= cycles_nxt_s;
      beats_r  <= beats_nxt_s;
    end
  end

  // Sticky status bits; a hardware set wins over a same-cycle W1C
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      done_r <= 1'b0;
    end else if (start_go_s) begin
      done_r <= 1'b0;
    end else if (done_set_s) begin
      done_r <= 1'b1;
    end else if (status_wr_s && cfg_wdata[1]) begin
      done_r <= 1'b0;
    end
  end

`ifdef CL_STREAM_TIMEOUT_EN
  // Timeout sticky bit and programmable limit
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      timeout_r     <= 1'b0;
      timeout_lim_r <= DEF_TIMEOUT;
    end else begin
      if (start_go_s) begin
        timeout_r <= 1'b0;
      end else if (tmo_fire_s) begin
        timeout_r <= 1'b1;
      end else if (status_wr_s && cfg_wdata[2]) begin
        timeout_r <= 1'b0;
      end
      if (tmo_wr_s) begin
        timeout_lim_r <= cfg_wdata;
      end
    end
  end
`endif

  // Scratch register
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      scratch_r <= 32'd0;
    end else if (scratch_wr_s) begin
      scratch_r <= cfg_wdata;
    end
  end

  // One ack per request; rdata only reloads on a pure read
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      cfg_ack   <= 1'b0;
      cfg_rdata <= 32'd0;
    end else begin
      cfg_ack <= cfg_wr || cfg_rd;
      if (cfg_rd && !cfg_wr) begin
        cfg_rdata <= rdata_s;
      end
    end
  end

endmodule
